// File: rtl/hex_scroll_ctrl.sv
// Pushbutton-driven hex window viewer: loads a word from instruction memory on
// a center press and scrolls a DIGITS-wide nibble window across it.

module hex_scroll_deb #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int DEB_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic             pulse_r;
  logic [DEB_W-1:0] cnt_r;

  // Synchronize, then accept a new level only after DEB_CYCLES equal samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      pulse_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
      pulse_r <= 1'b0;
      if (sync2_r == level_r) begin
        cnt_r <= '0;
      end else if (cnt_r == DEB_LAST) begin
        level_r <= sync2_r;
        pulse_r <= sync2_r;
        cnt_r   <= '0;
      end else begin
        cnt_r <= cnt_r + DEB_W'(1);
      end
    end
  end

  assign pulse = pulse_r;

endmodule

module hex_scroll_ctrl #(
  parameter int DATA_W     = 32,
  parameter int DIGITS     = 4,
  parameter int DEB_CYCLES = 250000,
  parameter int AUTO_DIV   = 50000000,
  parameter int LD_TIMEOUT = 16,
  parameter int ADDR_W     = 8,
  parameter int MAXP       = DATA_W / 4 - DIGITS,
  parameter int IDX_W      = (MAXP > 0) ? $clog2(MAXP + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  btn_right,
  input  logic                  btn_left,
  input  logic                  btn_center,
  input  logic                  mode_auto,
  input  logic                  wrap_en,
  output logic                  ld_req,
  output logic [ADDR_W-1:0]     ld_addr,
  input  logic                  ld_ack,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [4*DIGITS-1:0]   win,
  output logic [IDX_W-1:0]      idx,
  output logic [DATA_W-1:0]     held_word,
  output logic                  ld_err
);

  localparam int TICK_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam int TMO_W  = (LD_TIMEOUT > 1) ? $clog2(LD_TIMEOUT) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LD_TIMEOUT - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX   = IDX_W'(MAXP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_SHOW = 2'd2
  } state_t;

  state_t              state_r;
  state_t              ret_state_r;
  logic                ld_req_r;
  logic [ADDR_W-1:0]   ld_addr_r;
  logic                ld_err_r;
  logic [DATA_W-1:0]   held_word_r;
  logic [IDX_W-1:0]    idx_r;
  logic [4*DIGITS-1:0] win_r;
  logic [TICK_W-1:0]   tick_cnt_r;
  logic [TMO_W-1:0]    tmo_cnt_r;

  logic                right_pulse_s;
  logic                left_pulse_s;
  logic                center_pulse_s;
  logic [IDX_W-1:0]    right_next_s;
  logic [IDX_W-1:0]    left_next_s;
  logic [DATA_W-1:0]   shifted_s;

  function automatic logic [IDX_W-1:0] idx_inc_wrap(input logic [IDX_W-1:0] i);
    idx_inc_wrap = (i >= IDX_MAX) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] idx_dec_wrap(input logic [IDX_W-1:0] i);
    idx_dec_wrap = (i == '0) ? IDX_MAX : i - IDX_W'(1);
  endfunction

  hex_scroll_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right (
    .clk(clk), .rst(rst), .btn(btn_right), .pulse(right_pulse_s)
  );
  hex_scroll_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left (
    .clk(clk), .rst(rst), .btn(btn_left), .pulse(left_pulse_s)
  );
  hex_scroll_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_center (
    .clk(clk), .rst(rst), .btn(btn_center), .pulse(center_pulse_s)
  );

  // Next manual index: wrap or saturate at the ends depending on wrap_en.
  always_comb begin
    right_next_s = idx_r;
    left_next_s  = idx_r;
    if (wrap_en) begin
      right_next_s = idx_inc_wrap(idx_r);
      left_next_s  = idx_dec_wrap(idx_r);
    end else begin
      if (idx_r < IDX_MAX) begin
        right_next_s = idx_r + IDX_W'(1);
      end else begin
        right_next_s = idx_r;
      end
      if (idx_r != '0) begin
        left_next_s = idx_r - IDX_W'(1);
      end else begin
        left_next_s = idx_r;
      end
    end
  end

  assign shifted_s = held_word_r >> {idx_r, 2'b00};

  // Control FSM, scroll position, auto tick and load timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ret_state_r <= ST_IDLE;
      ld_req_r    <= 1'b0;
      ld_addr_r   <= '0;
      ld_err_r    <= 1'b0;
      held_word_r <= '0;
      idx_r       <= '0;
      win_r       <= '0;
      tick_cnt_r  <= '0;
      tmo_cnt_r   <= '0;
    end else begin
      win_r <= shifted_s[4*DIGITS-1:0];
      case (state_r)
        ST_IDLE, ST_SHOW: begin
          if (center_pulse_s) begin
            ret_state_r <= state_r;
            state_r     <= ST_LOAD;
            ld_req_r    <= 1'b1;
            tmo_cnt_r   <= '0;
            tick_cnt_r  <= '0;
          end else if (right_pulse_s || left_pulse_s) begin
            // A manual press wins over a coincident tick and restarts it.
            tick_cnt_r <= '0;
            if (right_pulse_s && !left_pulse_s) begin
              idx_r <= right_next_s;
            end else if (left_pulse_s && !right_pulse_s) begin
              idx_r <= left_next_s;
            end
          end else if (mode_auto) begin
            if (tick_cnt_r == TICK_LAST) begin
              tick_cnt_r <= '0;
              idx_r      <= idx_inc_wrap(idx_r);
            end else begin
              tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
          end else begin
            tick_cnt_r <= '0;
          end
        end
        ST_LOAD: begin
          tick_cnt_r <= '0;
          if (ld_ack) begin
            state_r     <= ST_SHOW;
            held_word_r <= ld_data;
            idx_r       <= '0;
            ld_addr_r   <= ld_addr_r + ADDR_W'(1);
            ld_err_r    <= 1'b0;
            ld_req_r    <= 1'b0;
          end else if (tmo_cnt_r == TMO_LAST) begin
            state_r  <= ret_state_r;
            ld_req_r <= 1'b0;
            ld_err_r <= 1'b1;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          ld_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign ld_req    = ld_req_r;
  assign ld_addr   = ld_addr_r;
  assign ld_err    = ld_err_r;
  assign held_word = held_word_r;
  assign idx       = idx_r;
  assign win       = win_r;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Directed bench for hex_scroll_ctrl with small debounce/tick/timeout values.

module tb_hex_scroll_ctrl;

  logic        clk;
  logic        rst;
  logic        btn_right;
  logic        btn_left;
  logic        btn_center;
  logic        mode_auto;
  logic        wrap_en;
  logic        ld_req;
  logic [7:0]  ld_addr;
  logic        ld_ack;
  logic [31:0] ld_data;
  logic [15:0] win;
  logic [2:0]  idx;
  logic [31:0] held_word;
  logic        ld_err;

  int total;
  int bad;

  logic [2:0]  exp_idx [5];
  logic [15:0] exp_win [5];

  hex_scroll_ctrl #(
    .DATA_W(32), .DIGITS(4), .DEB_CYCLES(4), .AUTO_DIV(8),
    .LD_TIMEOUT(16), .ADDR_W(8)
  ) dut (
    .clk(clk), .rst(rst), .btn_right(btn_right), .btn_left(btn_left),
    .btn_center(btn_center), .mode_auto(mode_auto), .wrap_en(wrap_en),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_ack(ld_ack), .ld_data(ld_data),
    .win(win), .idx(idx), .held_word(held_word), .ld_err(ld_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic press(input int which);
    if (which == 0) btn_right = 1'b1;
    else if (which == 1) btn_left = 1'b1;
    else btn_center = 1'b1;
    step(12);
    btn_right  = 1'b0;
    btn_left   = 1'b0;
    btn_center = 1'b0;
    step(12);
  endtask

  task automatic start_load();
    int n;
    n = 0;
    btn_center = 1'b1;
    while (ld_req !== 1'b1 && n < 40) begin
      step(1);
      n++;
    end
    btn_center = 1'b0;
    chk("ld_req_rise", 64'(ld_req), 64'd1);
  endtask

  initial begin
    total = 0;
    bad = 0;
    exp_idx[0] = 3'd1; exp_idx[1] = 3'd2; exp_idx[2] = 3'd3;
    exp_idx[3] = 3'd4; exp_idx[4] = 3'd4;
    exp_win[0] = 16'h4567; exp_win[1] = 16'h3456; exp_win[2] = 16'h2345;
    exp_win[3] = 16'h1234; exp_win[4] = 16'h1234;
    rst = 1'b1; btn_right = 1'b0; btn_left = 1'b0; btn_center = 1'b0;
    mode_auto = 1'b0; wrap_en = 1'b0; ld_ack = 1'b0; ld_data = 32'h0;
    step(3);
    chk("rst_idx", 64'(idx), 64'd0);
    chk("rst_held", 64'(held_word), 64'd0);
    chk("rst_win", 64'(win), 64'd0);
    chk("rst_ld_req", 64'(ld_req), 64'd0);
    chk("rst_ld_addr", 64'(ld_addr), 64'd0);
    chk("rst_ld_err", 64'(ld_err), 64'd0);
    rst = 1'b0;
    step(2);

    // First load, acknowledged three cycles after the request
    start_load();
    step(2);
    ld_ack = 1'b1; ld_data = 32'h12345678;
    step(1);
    ld_ack = 1'b0; ld_data = 32'h0;
    chk("load_held", 64'(held_word), 64'h12345678);
    chk("load_idx", 64'(idx), 64'd0);
    chk("load_addr", 64'(ld_addr), 64'd1);
    chk("load_req_low", 64'(ld_req), 64'd0);
    step(1);
    chk("load_win", 64'(win), 64'h5678);
    step(12);

    // Saturating right scroll, then one left
    for (int i = 0; i < 5; i++) begin
      press(0);
      chk("sat_right_idx", 64'(idx), 64'(exp_idx[i]));
      chk("sat_right_win", 64'(win), 64'(exp_win[i]));
    end
    press(1);
    chk("left_idx", 64'(idx), 64'd3);
    chk("left_win", 64'(win), 64'h2345);

    // Wrapping scroll at both ends
    wrap_en = 1'b1;
    press(0);
    chk("wrap_pre_idx", 64'(idx), 64'd4);
    press(0);
    chk("wrap_right_idx", 64'(idx), 64'd0);
    chk("wrap_right_win", 64'(win), 64'h5678);
    press(1);
    chk("wrap_left_idx", 64'(idx), 64'd4);

    // Two-cycle glitch is filtered; a long hold steps once
    btn_right = 1'b1;
    step(2);
    btn_right = 1'b0;
    step(20);
    chk("glitch_idx", 64'(idx), 64'd4);
    btn_right = 1'b1;
    step(100);
    btn_right = 1'b0;
    step(12);
    chk("hold_idx", 64'(idx), 64'd0);
    wrap_en = 1'b0;
    press(1);
    chk("sat_left_idx", 64'(idx), 64'd0);

    // Load timeout, then a successful load clears the error
    start_load();
    step(15);
    chk("tmo_req_still", 64'(ld_req), 64'd1);
    step(1);
    chk("tmo_req_low", 64'(ld_req), 64'd0);
    chk("tmo_err", 64'(ld_err), 64'd1);
    chk("tmo_held", 64'(held_word), 64'h12345678);
    chk("tmo_addr", 64'(ld_addr), 64'd1);
    step(12);
    start_load();
    ld_ack = 1'b1; ld_data = 32'hCAFEF00D;
    step(1);
    ld_ack = 1'b0; ld_data = 32'h0;
    chk("reload_err", 64'(ld_err), 64'd0);
    chk("reload_held", 64'(held_word), 64'hCAFEF00D);
    chk("reload_addr", 64'(ld_addr), 64'd2);
    step(1);
    chk("reload_win", 64'(win), 64'hF00D);
    step(12);

    // Auto scroll every 8 cycles, always wrapping
    mode_auto = 1'b1;
    step(7);
    chk("auto_before", 64'(idx), 64'd0);
    step(1);
    chk("auto_1", 64'(idx), 64'd1);
    for (int i = 2; i <= 5; i++) begin
      step(8);
      chk("auto_step", 64'(idx), 64'(i % 5));
    end
    // Simultaneous left+right: no move, tick counter restarts
    btn_right = 1'b1; btn_left = 1'b1;
    step(7);
    btn_right = 1'b0; btn_left = 1'b0;
    chk("both_idx", 64'(idx), 64'd0);
    step(1);
    chk("restart_no_tick", 64'(idx), 64'd0);
    step(6);
    chk("restart_before", 64'(idx), 64'd0);
    step(1);
    chk("restart_tick", 64'(idx), 64'd1);
    mode_auto = 1'b0;
    step(12);

    // Reset during a pending load
    start_load();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("rst_load_req", 64'(ld_req), 64'd0);
    chk("rst_load_err", 64'(ld_err), 64'd0);
    chk("rst_load_addr", 64'(ld_addr), 64'd0);
    step(20);
    chk("rst_load_stay", 64'(ld_req), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
